// File: rtl/k12a_skip_ctrl_pkg.sv
// k12a skip controller shared types.
// Skip-select encodings and default sizing constants.
package k12a_pkg;

  localparam int K12A_MAX_SKIP = 3;
  localparam int K12A_NUM_COND = 4;

  typedef enum logic [2:0] {
    SKIP_SEL_HOLD        = 3'd0,
    SKIP_SEL_0           = 3'd1,
    SKIP_SEL_CONDITION   = 3'd2,
    SKIP_SEL_CONDITION_N = 3'd3,
    SKIP_SEL_ALWAYS      = 3'd4
  } skip_sel_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SKIPPING = 1'b1
  } skip_state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/k12a_skip_ctrl_if.sv
// k12a skip controller bundle.
// Master drives select/condition/retire, slave returns skip state.
interface k12a_skip_ctrl_if
  import k12a_pkg::*;
#(
  parameter int NUM_COND = K12A_NUM_COND,
  parameter int MAX_SKIP = K12A_MAX_SKIP
) ();

  localparam int CNT_W      = $clog2(MAX_SKIP + 1);
  localparam int COND_IDX_W = idx_w(NUM_COND);

  logic [NUM_COND-1:0]   cond_in;
  logic [COND_IDX_W-1:0] cond_idx;
  skip_sel_t             skip_sel;
  logic [CNT_W-1:0]      skip_len;
  logic                  instr_retire;
  logic                  skip;
  logic [CNT_W-1:0]      skip_remaining;

  modport master (
    output cond_in, cond_idx, skip_sel,
    output skip_len, instr_retire,
    input  skip, skip_remaining
  );

  modport slave (
    input  cond_in, cond_idx, skip_sel,
    input  skip_len, instr_retire,
    output skip, skip_remaining
  );

endinterface

// File: rtl/k12a_cond_mux.sv
// Condition channel select.
// Indices past the last channel read as false.
module k12a_cond_mux #(
  parameter int NUM_COND   = 4,
  parameter int COND_IDX_W = 2
) (
  input  logic [NUM_COND-1:0]   cond_in,
  input  logic [COND_IDX_W-1:0] cond_idx,
  output logic                  cond
);

  // Match the index against each real channel; no match leaves 0.
  always_comb begin
    cond = 1'b0;
    for (int i = 0; i < NUM_COND; i++) begin
      if (cond_idx == COND_IDX_W'(i)) begin
        cond = cond_in[i];
      end
    end
  end

endmodule

// File: rtl/k12a_skip_ctrl.sv
// k12a multi-instruction skip controller.
// Counts down suppressed instructions after a condition arms it.
module k12a_skip_ctrl
  import k12a_pkg::*;
#(
  parameter int NUM_COND = K12A_NUM_COND,
  parameter int MAX_SKIP = K12A_MAX_SKIP
) (
  input logic              clock,
  input logic              reset,
  k12a_skip_ctrl_if.slave  bus
);

  localparam int CNT_W      = $clog2(MAX_SKIP + 1);
  localparam int COND_IDX_W = idx_w(NUM_COND);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SKIP);

  logic             cond;
  logic             arm;
  logic             clear;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  skip_state_t      state;

  k12a_cond_mux #(
    .NUM_COND   (NUM_COND),
    .COND_IDX_W (COND_IDX_W)
  ) u_cond_mux (
    .cond_in  (bus.cond_in),
    .cond_idx (bus.cond_idx),
    .cond     (cond)
  );

  // Decode the select into arm/clear and clamp the requested length.
  always_comb begin
    arm   = 1'b0;
    clear = 1'b0;
    case (bus.skip_sel)
      SKIP_SEL_0:           clear = 1'b1;
      SKIP_SEL_CONDITION:   arm   = cond;
      SKIP_SEL_CONDITION_N: arm   = ~cond;
      SKIP_SEL_ALWAYS:      arm   = 1'b1;
      default:              arm   = 1'b0;
    endcase
    len_eff = (bus.skip_len > MAX_C) ? MAX_C : bus.skip_len;
  end

  // Clear wins; only an idle core may arm; retires drain a skip.
  always_comb begin
    state     = (count != '0) ? ST_SKIPPING : ST_IDLE;
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (state == ST_IDLE) begin
      if (arm) count_nxt = len_eff;
    end else if (bus.instr_retire) begin
      count_nxt = count - 1'b1;
    end
  end

  // Skip counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  assign bus.skip           = (state == ST_SKIPPING);
  assign bus.skip_remaining = count;

endmodule

// File: tb/tb_k12a_skip_ctrl.sv
// Bench for k12a_skip_ctrl.
// Random and directed stimulus against a queued reference model.
module tb_k12a_skip_ctrl;
  import k12a_pkg::*;

  localparam int NC = 3;
  localparam int MS = 5;
  localparam int CW = $clog2(MS + 1);
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  k12a_skip_ctrl_if #(.NUM_COND(NC), .MAX_SKIP(MS)) bus ();

  k12a_skip_ctrl #(.NUM_COND(NC), .MAX_SKIP(MS)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int   expq[$];
  int   total = 0;
  int   bad = 0;
  int   mdl = 0;
  event aev;

  function automatic int model(int cnt, int sel, int idx,
                               logic [NC-1:0] cond, int len, bit ret);
    bit c;
    bit arm;
    int l;
    c   = (idx < NC) ? cond[idx] : 1'b0;
    arm = (sel == 4) || (sel == 2 && c) || (sel == 3 && !c);
    l   = (len > MS) ? MS : len;
    if (sel == 1) return 0;
    if (cnt == 0) return arm ? l : 0;
    return ret ? cnt - 1 : cnt;
  endfunction

  task automatic chk();
    int e;
    if (expq.size() == 0) return;
    e = expq.pop_front();
    total += 2;
    if (bus.skip !== (e != 0)) begin
      bad++;
      $display("FAIL skip: got %b want %b t=%0t",
               bus.skip, (e != 0), $time);
    end
    if (bus.skip_remaining !== CW'(e)) begin
      bad++;
      $display("FAIL remaining: got %0d want %0d t=%0t",
               bus.skip_remaining, e, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk();
  end

  always @(aev) begin
    #1;
    chk();
  end

  task automatic step(int sel, int idx, int cond, int len, bit ret);
    @(negedge clk);
    bus.skip_sel     = skip_sel_t'(sel[2:0]);
    bus.cond_idx     = idx[IW-1:0];
    bus.cond_in      = cond[NC-1:0];
    bus.skip_len     = len[CW-1:0];
    bus.instr_retire = ret;
    if (rst) mdl = 0;
    else mdl = model(mdl, sel, idx, cond[NC-1:0], len, ret);
    expq.push_back(mdl);
  endtask

  task automatic async_pulse();
    @(negedge clk);
    bus.skip_sel     = SKIP_SEL_HOLD;
    bus.instr_retire = 1'b0;
    #2 rst = 1'b1;
    mdl = 0;
    expq.push_back(0);
    -> aev;
    #2 rst = 1'b0;
    expq.push_back(0);
  endtask

  initial begin
    bus.skip_sel     = SKIP_SEL_ALWAYS;
    bus.cond_idx     = '0;
    bus.cond_in      = '0;
    bus.skip_len     = CW'(2);
    bus.instr_retire = 1'b0;
    #1;
    expq.push_back(0);
    -> aev;

    repeat (3) step(4, 0, 0, 2, 1);
    @(negedge clk);
    bus.skip_sel = SKIP_SEL_HOLD;
    rst = 1'b0;
    expq.push_back(0);

    step(2, 2, 3'b100, 2, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    step(3, 1, 3'b000, 7, 1);
    step(1, 0, 0, 0, 0);

    step(4, 0, 0, 2, 1);
    step(4, 0, 0, 3, 1);
    step(1, 0, 0, 0, 0);

    step(2, 0, 3'b001, 0, 1);
    step(2, 3, 3'b111, 2, 0);
    step(3, 3, 3'b111, 2, 0);
    step(1, 0, 0, 0, 0);

    step(4, 0, 0, 3, 0);
    step(6, 0, 0, 0, 1);
    step(7, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(7, 0, 0, 4, 1);

    step(4, 0, 0, 3, 0);
    async_pulse();
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_pulse();
      end else begin
        step($urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom_range(0, 1)));
      end
    end

    @(posedge clk);
    #3;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
